uart_receiver: RTL and testbench

Serial-to-parallel UART receiver that consumes the transmitter's serial line and returns 8-bit frames (Hamming-encoded payload, decoded downstream) to the parallel domain. It has a 2-flop input synchroniser, mid-bit sampling at 8 clocks per bit, and framing-error detection. Received bytes are held in a one-entry valid/ready output register, with overrun reporting. It sits between the serial line (loopback of `tx` in test) and the Hamming decoder.

---
 rtl/uart_receiver.sv | 173 +++++++++++++++++
 tb/tb_uart_receiver.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_receiver.sv
// uart_receiver
//   Serial-to-parallel UART receiver: 8N1, LSB first, idle-high line.
//   The asynchronous line goes through a 2-flop synchroniser. A start bit is
//   confirmed at its mid-point, and each data/stop bit is sampled one full bit
//   period after the previous sample. Good bytes land in a one-entry
//   valid/ready holding register. If that register is still full, the new byte
//   is dropped and a sticky overrun flag is set.
//
// Ports
//   clk          : clock, all logic on posedge
//   rst_n        : synchronous active-low reset
//   rx           : asynchronous serial input (idle 1, start 0, 8 data, stop 1)
//   rx_data[7:0] : received byte, meaningful while rx_valid is high
//   rx_valid     : holding register full
//   rx_ready     : consumer takes rx_data when rx_valid && rx_ready at posedge
//   rx_frame_err : one-cycle pulse when a stop bit is sampled low
//   rx_overrun   : sticky; a good frame was dropped because the register was full
//   rx_busy      : receiver FSM is not idle
//
// Handshake: a transfer happens on every posedge where rx_valid && rx_ready.
// rx_valid never drops without a transfer. rx_ready has no effect while
// rx_valid is low.
module uart_receiver #(
  parameter int CLKS_PER_BIT = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       rx_frame_err,
  output logic       rx_overrun,
  output logic       rx_busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_IDLE = 3'd4
  } state_t;

  state_t        state, state_nx;
  logic          s1, rx_s;
  logic [1:0]    sync_fill;
  logic          armed;
  logic [CW-1:0] clk_cnt, clk_cnt_nx;
  logic [2:0]    bit_idx, bit_idx_nx;
  logic [7:0]    shift, shift_nx;
  logic          frame_ok, frame_bad;

  // Synchroniser and arm flag. The synchroniser flops reset to 1, so for the
  // first two cycles after reset rx_s still shows the reset value and not
  // the line. sync_fill tracks when rx_s carries a real line sample. This
  // keeps a line held low through reset from arming the receiver.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1        <= 1'b1;
      rx_s      <= 1'b1;
      sync_fill <= 2'b00;
      armed     <= 1'b0;
    end else begin
      s1        <= rx;
      rx_s      <= s1;
      sync_fill <= {sync_fill[0], 1'b1};
      if (sync_fill[1] && rx_s) armed <= 1'b1;
    end
  end

  // FSM state and bit-timing registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      clk_cnt <= '0;
      bit_idx <= 3'd0;
      shift   <= 8'h00;
    end else begin
      state   <= state_nx;
      clk_cnt <= clk_cnt_nx;
      bit_idx <= bit_idx_nx;
      shift   <= shift_nx;
    end
  end

  // Next-state logic. The START check happens half a bit after the synchronised
  // edge. From there each full-bit count lands on the middle of the next bit.
  always_comb begin
    state_nx   = state;
    clk_cnt_nx = clk_cnt;
    bit_idx_nx = bit_idx;
    shift_nx   = shift;
    frame_ok   = 1'b0;
    frame_bad  = 1'b0;
    case (state)
      IDLE: begin
        clk_cnt_nx = '0;
        bit_idx_nx = 3'd0;
        if (armed && !rx_s) state_nx = START;
      end
      START: begin
        if (clk_cnt == CNT_HALF) begin
          clk_cnt_nx = '0;
          // The line is high again at mid-start, so this was a glitch.
          state_nx   = rx_s ? IDLE : DATA;
        end else begin
          clk_cnt_nx = clk_cnt + 1'b1;
        end
      end
      DATA: begin
        if (clk_cnt == CNT_LAST) begin
          clk_cnt_nx = '0;
          shift_nx   = {rx_s, shift[7:1]};
          bit_idx_nx = bit_idx + 3'd1;
          if (bit_idx == 3'd7) state_nx = STOP;
        end else begin
          clk_cnt_nx = clk_cnt + 1'b1;
        end
      end
      STOP: begin
        if (clk_cnt == CNT_LAST) begin
          clk_cnt_nx = '0;
          if (rx_s) begin
            frame_ok = 1'b1;
            state_nx = IDLE;
          end else begin
            frame_bad = 1'b1;
            state_nx  = WAIT_IDLE;
          end
        end else begin
          clk_cnt_nx = clk_cnt + 1'b1;
        end
      end
      WAIT_IDLE: begin
        // Break or stuck-low line: wait for the line to go high before
        // accepting another start bit.
        clk_cnt_nx = '0;
        if (rx_s) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign rx_busy = (state != IDLE);

  // Holding register. When a new byte arrives in the same cycle as a drain,
  // the new byte is loaded directly. The overrun set takes priority over
  // the handshake clear.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_data      <= 8'h00;
      rx_valid     <= 1'b0;
      rx_overrun   <= 1'b0;
      rx_frame_err <= 1'b0;
    end else begin
      rx_frame_err <= frame_bad;
      if (frame_ok && (!rx_valid || rx_ready)) begin
        rx_data  <= shift;
        rx_valid <= 1'b1;
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
      if (frame_ok && rx_valid && !rx_ready) rx_overrun <= 1'b1;
      else if (rx_valid && rx_ready)         rx_overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_receiver.sv
// tb_uart_receiver
//   Bench for uart_receiver. Inputs change on the negedge of the clock.
//   Outputs are sampled 2 time units after each negedge.
//   A transaction-level model predicts the outputs. It tracks each frame's
//   completion cycle (78 clocks after the start edge) and whether the frame
//   is good or bad. A queue holds the byte expected in the holding register.
module tb_uart_receiver;
  localparam int CPB = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx = 1'b1;
  logic       rx_ready = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid, rx_frame_err, rx_overrun, rx_busy;

  uart_receiver #(.CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .rst_n(rst_n), .rx(rx),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .rx_frame_err(rx_frame_err), .rx_overrun(rx_overrun), .rx_busy(rx_busy)
  );

  // ---------------- clock / reset / cycle counter ----------------
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- bookkeeping ----------------
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got 0x%0h expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  // ---------------- reference model / scoreboard ----------------
  logic [7:0] exp_q[$];        // byte expected in the holding register
  logic       m_ovr = 1'b0;
  int         err_cyc = -1;    // sample cycle where the frame_err pulse is due
  bit         model_on = 1'b0;
  int         pend_cyc[$];     // sample cycle just before each frame completes
  logic [7:0] pend_data[$];
  bit         pend_good[$];
  int         err_seen = 0;
  int         deliveries = 0;
  int         frames_started = 0;
  int         last_start = 0;

  task automatic model_clear();
    exp_q.delete();
    pend_cyc.delete();
    pend_data.delete();
    pend_good.delete();
    m_ovr   = 1'b0;
    err_cyc = -1;
  endtask

  task automatic model_step();
    bit         full, hs, done, good;
    logic [7:0] d;
    full = (exp_q.size() != 0);
    check("valid", 32'(rx_valid), 32'(full));
    check("overrun", 32'(rx_overrun), 32'(m_ovr));
    check("frame_err", 32'(rx_frame_err), 32'(cyc == err_cyc));
    if (full) check("data", 32'(rx_data), 32'(exp_q[0]));
    // Compute what the coming posedge does.
    hs   = full && rx_ready;
    done = (pend_cyc.size() != 0) && (pend_cyc[0] == cyc);
    good = 1'b0;
    d    = 8'h00;
    if (done) begin
      good = pend_good.pop_front();
      d    = pend_data.pop_front();
      void'(pend_cyc.pop_front());
    end
    if (hs) begin
      void'(exp_q.pop_front());
      deliveries++;
    end
    if (done && good && full && !rx_ready) m_ovr = 1'b1;
    else if (hs)                           m_ovr = 1'b0;
    if (done && good && (!full || rx_ready)) exp_q.push_back(d);
    if (done && !good) err_cyc = cyc + 1;
  endtask

  always @(negedge clk) begin
    #2;
    if (rx_frame_err === 1'b1) err_seen++;
    if (model_on) model_step();
  end

  // ---------------- drivers (called at a negedge, return at a negedge) ----------------
  task automatic drive_bit(input logic b, input int n);
    rx = b;
    repeat (n) @(negedge clk);
  endtask

  task automatic idle(input int n);
    drive_bit(1'b1, n);
  endtask

  // Leaves rx at the stop-bit level.
  task automatic send_frame(input logic [7:0] d, input logic stop, input int start_len);
    last_start = cyc;
    frames_started++;
    if (model_on) begin
      pend_cyc.push_back(cyc + 78);
      pend_data.push_back(d);
      pend_good.push_back(stop);
    end
    drive_bit(1'b0, start_len);
    for (int k = 0; k < 8; k++) drive_bit(d[k], CPB);
    drive_bit(stop, CPB);
  endtask

  // ---------------- directed vectors ----------------
  typedef struct {
    logic [7:0] data;
    logic       stop;
    int         start_len;
    logic       exp_valid;
    logic [7:0] exp_data;
    int         exp_errs;
  } vec_t;
  vec_t vecs[6];

  int e0, d0, fs0, c2, gap;
  logic [7:0] rd;
  logic       rstop;
  bit         rand_done;

  initial begin
    vecs[0] = '{8'hA5, 1'b1, 8, 1'b1, 8'hA5, 0};
    vecs[1] = '{8'h00, 1'b1, 8, 1'b1, 8'h00, 0};
    vecs[2] = '{8'hFF, 1'b1, 9, 1'b1, 8'hFF, 0};
    vecs[3] = '{8'h81, 1'b0, 8, 1'b0, 8'h00, 1};
    vecs[4] = '{8'h3C, 1'b1, 9, 1'b1, 8'h3C, 0};
    vecs[5] = '{8'h96, 1'b0, 9, 1'b0, 8'h00, 1};

    // Reset state
    repeat (3) @(negedge clk);
    #2;
    check("rst rx_data", 32'(rx_data), 32'h00);
    check("rst rx_valid", 32'(rx_valid), 32'h0);
    check("rst rx_frame_err", 32'(rx_frame_err), 32'h0);
    check("rst rx_overrun", 32'(rx_overrun), 32'h0);
    check("rst rx_busy", 32'(rx_busy), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    model_on = 1'b1;
    idle(6);

    // Single byte with rx_ready held high
    e0 = err_seen; d0 = deliveries;
    rx_ready = 1'b1;
    send_frame(8'hA5, 1'b1, CPB);
    #2;
    check("single dropped", 32'(rx_valid), 32'h0);
    check("single delivered", 32'(deliveries - d0), 32'd1);
    check("single no err", 32'(err_seen - e0), 32'd0);
    @(negedge clk);
    idle(3);
    rx_ready = 1'b0;

    // Table of isolated frames: inspect the holding register, then drain it
    for (int i = 0; i < 6; i++) begin
      e0 = err_seen;
      send_frame(vecs[i].data, vecs[i].stop, vecs[i].start_len);
      idle(4);
      #2;
      check("vec valid", 32'(rx_valid), 32'(vecs[i].exp_valid));
      if (vecs[i].exp_valid) check("vec data", 32'(rx_data), 32'(vecs[i].exp_data));
      check("vec errs", 32'(err_seen - e0), 32'(vecs[i].exp_errs));
      check("vec overrun", 32'(rx_overrun), 32'h0);
      check("vec busy", 32'(rx_busy), 32'h0);
      @(negedge clk);
      rx_ready = 1'b1;
      @(negedge clk);
      rx_ready = 1'b0;
      #2;
      check("vec drained", 32'(rx_valid), 32'h0);
      @(negedge clk);
    end

    // Glitch: line low for 2 clocks
    e0 = err_seen; d0 = deliveries;
    drive_bit(1'b0, 2);
    idle(12);
    #2;
    check("glitch busy", 32'(rx_busy), 32'h0);
    check("glitch valid", 32'(rx_valid), 32'h0);
    check("glitch err", 32'(err_seen - e0), 32'd0);
    @(negedge clk);
    rx_ready = 1'b1;
    send_frame(8'h3C, 1'b1, CPB);
    idle(4);
    rx_ready = 1'b0;
    check("after glitch delivered", 32'(deliveries - d0), 32'd1);

    // Framing error followed by a long low line
    e0 = err_seen; d0 = deliveries;
    send_frame(8'h81, 1'b0, CPB);
    rx = 1'b0;
    for (int i = 0; i < 20; i++) begin
      #2;
      check("break busy", 32'(rx_busy), 32'h1);
      @(negedge clk);
    end
    idle(6);
    #2;
    check("break busy released", 32'(rx_busy), 32'h0);
    check("break one err", 32'(err_seen - e0), 32'd1);
    check("break no valid", 32'(rx_valid), 32'h0);
    @(negedge clk);
    rx_ready = 1'b1;
    send_frame(8'h7E, 1'b1, CPB);
    idle(4);
    rx_ready = 1'b0;
    check("after break delivered", 32'(deliveries - d0), 32'd1);

    // Overrun: two back-to-back frames with no drain
    send_frame(8'h11, 1'b1, CPB);
    send_frame(8'h22, 1'b1, CPB);
    idle(3);
    #2;
    check("ovr valid", 32'(rx_valid), 32'h1);
    check("ovr data kept", 32'(rx_data), 32'h11);
    check("ovr flag", 32'(rx_overrun), 32'h1);
    @(negedge clk);
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
    #2;
    check("ovr drained valid", 32'(rx_valid), 32'h0);
    check("ovr cleared", 32'(rx_overrun), 32'h0);
    @(negedge clk);

    // Drain and load in the same cycle (rx_ready only at E78 of frame 2)
    fs0 = frames_started;
    fork
      begin
        send_frame(8'h55, 1'b1, CPB);
        send_frame(8'hAA, 1'b1, CPB);
      end
      begin
        wait (frames_started == fs0 + 2);
        c2 = last_start;
        for (int i = 0; i < 200 && cyc != c2 + 78; i++) @(negedge clk);
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
      end
    join
    idle(3);
    #2;
    check("simul valid", 32'(rx_valid), 32'h1);
    check("simul data", 32'(rx_data), 32'hAA);
    check("simul no ovr", 32'(rx_overrun), 32'h0);
    @(negedge clk);
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;

    // Reset during bit 4, released while the line is low
    model_on = 1'b0;
    e0 = err_seen;
    drive_bit(1'b0, CPB);
    for (int k = 0; k < 4; k++) drive_bit(k[0], CPB);
    drive_bit(1'b1, 3);
    rst_n = 1'b0;
    rx = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 30; i++) begin
      #2;
      check("low-line busy", 32'(rx_busy), 32'h0);
      check("low-line valid", 32'(rx_valid), 32'h0);
      @(negedge clk);
    end
    check("reset no err", 32'(err_seen - e0), 32'd0);
    model_clear();
    model_on = 1'b1;
    d0 = deliveries;
    idle(6);
    rx_ready = 1'b1;
    send_frame(8'hC3, 1'b1, CPB);
    send_frame(8'hC3, 1'b1, CPB + 1);
    idle(4);
    rx_ready = 1'b0;
    check("after reset delivered", 32'(deliveries - d0), 32'd2);

    // Randomised frames with random consumer back-pressure
    rand_done = 1'b0;
    fork
      begin
        for (int f = 0; f < 24; f++) begin
          rd    = 8'($urandom_range(0, 255));
          rstop = ($urandom_range(0, 5) != 0);
          send_frame(rd, rstop, ($urandom_range(0, 1) != 0) ? CPB + 1 : CPB);
          gap = rstop ? $urandom_range(0, 5) : $urandom_range(2, 6);
          idle(gap);
        end
        idle(4);
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          rx_ready = ($urandom_range(0, 3) == 0);
          @(negedge clk);
        end
        rx_ready = 1'b0;
      end
    join
    rx_ready = 1'b1;
    idle(4);
    rx_ready = 1'b0;
    check("final queue empty", 32'(exp_q.size()), 32'd0);
    check("final pending empty", 32'(pend_cyc.size()), 32'd0);
    check("final valid", 32'(rx_valid), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
